// File: rtl/mb_loop_scheduler.sv
// ---------------------------------------------------------------------------
// mb_loop_scheduler
//
// Issue-slot scheduler for the mandelbulb iteration loop. Every cycle the
// single loop issue slot is filled with either a ray coming back from the
// end of the loop (recirculation, always wins) or a freshly generated ray.
// Rays that escaped (r > threshold) or hit the iteration limit are retired
// into a first-word-fall-through done FIFO feeding the march stage. A credit
// check (in_flight + fifo_cnt < FIFO_DEPTH) on admission guarantees that a
// retiring ray always finds room, so returns never stall.
//
// Parameters:
//   MAX_ITER    mandelbulb iterations per ray (>=1, fits in mb_iter)
//   FIFO_DEPTH  done FIFO entries and global ray credit (power of two, >=2)
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   start, flush               pulses: IDLE->RUN, RUN->DRAIN
//   busy                       high in RUN or DRAIN
//   new_valid/new_ready/new_msg   new-ray admission (new_ready is comb.)
//   issue_valid/issue_msg      registered loop input
//   ret_valid/ret_msg          loop output (returning ray)
//   done_valid/done_ready/done_msg  done FIFO head (FWFT)
//   err_sticky                 a return arrived with nothing in flight
//
// Optional feature (macro MB_SCHED_STATS_EN):
//   stat_retired  32-bit wrapping count of retirements
//   stat_idle     32-bit wrapping count of RUN cycles leaving the slot empty
// ---------------------------------------------------------------------------

package fixedpoint;
  localparam int MB_ITER_W = 8;
  typedef logic signed [15:0]  number;
  typedef logic [MB_ITER_W-1:0] iter_t;
  typedef struct packed {
    logic [7:0] ray_id;
    number      x;
    number      y;
    number      z;
    number      r;
    number      threshold;
    iter_t      mb_iter;
  } message;
endpackage

module mb_loop_scheduler #(
  parameter int MAX_ITER   = 8,
  parameter int FIFO_DEPTH = 128
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               flush,
  output logic               busy,
  input  logic               new_valid,
  output logic               new_ready,
  input  fixedpoint::message new_msg,
  output logic               issue_valid,
  output fixedpoint::message issue_msg,
  input  logic               ret_valid,
  input  fixedpoint::message ret_msg,
  output logic               done_valid,
  input  logic               done_ready,
  output fixedpoint::message done_msg,
  output logic               err_sticky
`ifdef MB_SCHED_STATS_EN
  ,
  output logic [31:0]        stat_retired,
  output logic [31:0]        stat_idle
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;  // counter width
  localparam int PW = $clog2(FIFO_DEPTH);      // pointer width
  localparam logic [CW:0] DEPTH_L = (CW+1)'(FIFO_DEPTH);
  localparam fixedpoint::iter_t ITER_LAST = fixedpoint::iter_t'(MAX_ITER - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [CW-1:0]      in_flight_reg, in_flight_next;
  logic [CW-1:0]      fifo_cnt_reg, fifo_cnt_next;
  logic [PW-1:0]      wr_ptr_reg, rd_ptr_reg;
  logic               issue_valid_reg;
  fixedpoint::message issue_msg_reg;
  logic               err_sticky_reg;
  fixedpoint::message fifo_mem [FIFO_DEPTH];

  logic               retire;
  logic               stray;
  logic               recirc;
  logic               push;
  logic               pop;
  logic               admit;
  logic [CW:0]        credit_sum;
  fixedpoint::message recirc_msg;
  fixedpoint::message admit_msg;

  // -------------------------------------------------------------------------
  // Return classification
  // -------------------------------------------------------------------------
  always_comb begin
    retire = ($signed(ret_msg.r) > $signed(ret_msg.threshold)) ||
             (ret_msg.mb_iter >= ITER_LAST);
    // A return with nothing in flight cannot belong to us (e.g. a ray that
    // was inside the loop across a reset); it is dropped without touching
    // the counters so the credit accounting stays consistent.
    stray  = ret_valid && (in_flight_reg == '0);
    recirc = ret_valid && !stray && !retire;
    push   = ret_valid && !stray && retire;
  end

  assign done_valid = (fifo_cnt_reg != '0);
  assign pop        = done_valid && done_ready;

  // Credit covers every ray that may still need a FIFO slot.
  assign credit_sum = {1'b0, in_flight_reg} + {1'b0, fifo_cnt_reg};
  assign new_ready  = (state_reg == RUN) && !(ret_valid && !retire) &&
                      (credit_sum < DEPTH_L);
  assign admit      = new_valid && new_ready;

  always_comb begin
    recirc_msg         = ret_msg;
    recirc_msg.mb_iter = ret_msg.mb_iter + 1'b1;
    admit_msg          = new_msg;
    admit_msg.mb_iter  = '0;
  end

  // -------------------------------------------------------------------------
  // Control FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (flush) state_next = DRAIN;
      DRAIN:   if ((in_flight_reg == '0) && (fifo_cnt_reg == '0)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state_reg != IDLE);

  // -------------------------------------------------------------------------
  // Credit counters
  // -------------------------------------------------------------------------
  always_comb begin
    in_flight_next = in_flight_reg + CW'(admit) - CW'(push);
    fifo_cnt_next  = fifo_cnt_reg + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_flight_reg  <= '0;
      fifo_cnt_reg   <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      err_sticky_reg <= 1'b0;
    end else begin
      in_flight_reg <= in_flight_next;
      fifo_cnt_reg  <= fifo_cnt_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;  // wraps modulo FIFO_DEPTH
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (stray) err_sticky_reg <= 1'b1;
    end
  end

  assign err_sticky = err_sticky_reg;

  // -------------------------------------------------------------------------
  // Issue slot register: recirculation strictly before admission
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      issue_valid_reg <= 1'b0;
      issue_msg_reg   <= '0;
    end else begin
      issue_valid_reg <= recirc || admit;
      if (recirc) begin
        issue_msg_reg <= recirc_msg;
      end else if (admit) begin
        issue_msg_reg <= admit_msg;
      end
    end
  end

  assign issue_valid = issue_valid_reg;
  assign issue_msg   = issue_msg_reg;

  // -------------------------------------------------------------------------
  // Done FIFO storage. The head is read asynchronously so done_msg is valid
  // in the same cycle done_valid rises; it is masked to zero while empty so
  // stale (or never-written) entries are not visible after reset.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= ret_msg;
    end
  end

  assign done_msg = done_valid ? fifo_mem[rd_ptr_reg] : '0;

`ifdef MB_SCHED_STATS_EN
  // -------------------------------------------------------------------------
  // Statistics
  // -------------------------------------------------------------------------
  logic [31:0] stat_retired_reg;
  logic [31:0] stat_idle_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_retired_reg <= '0;
      stat_idle_reg    <= '0;
    end else begin
      if (push) stat_retired_reg <= stat_retired_reg + 32'd1;
      // A RUN cycle whose next edge loads an empty issue slot.
      if ((state_reg == RUN) && !(recirc || admit)) stat_idle_reg <= stat_idle_reg + 32'd1;
    end
  end

  assign stat_retired = stat_retired_reg;
  assign stat_idle    = stat_idle_reg;
`endif

endmodule

// File: tb/tb_mb_loop_scheduler.sv
// ---------------------------------------------------------------------------
// tb_mb_loop_scheduler
//
// Randomised bench for mb_loop_scheduler. The loop itself is modelled as a
// fixed-latency delay line fed by the expected issue stream; each returning
// ray gets a new random r (sometimes above threshold). A transaction-level
// reference model (state, in-flight count, done queue, expected issue slot)
// predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_mb_loop_scheduler;
  import fixedpoint::*;

  localparam int MAX_ITER = 8;
  localparam int DEPTH    = 8;
  localparam int LAT      = 3;

  logic   clk = 1'b0;
  logic   rst_n, start, flush, busy;
  logic   new_valid, new_ready, issue_valid, ret_valid, done_valid, done_ready, err_sticky;
  message new_msg, issue_msg, ret_msg, done_msg;
`ifdef MB_SCHED_STATS_EN
  logic [31:0] stat_retired, stat_idle;
`endif

  always #5 clk = ~clk;

  mb_loop_scheduler #(.MAX_ITER(MAX_ITER), .FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .flush       (flush),
    .busy        (busy),
    .new_valid   (new_valid),
    .new_ready   (new_ready),
    .new_msg     (new_msg),
    .issue_valid (issue_valid),
    .issue_msg   (issue_msg),
    .ret_valid   (ret_valid),
    .ret_msg     (ret_msg),
    .done_valid  (done_valid),
    .done_ready  (done_ready),
    .done_msg    (done_msg),
    .err_sticky  (err_sticky)
`ifdef MB_SCHED_STATS_EN
    ,
    .stat_retired(stat_retired),
    .stat_idle   (stat_idle)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state
  int     m_st;          // 0 idle, 1 run, 2 drain
  int     m_inflight;
  message m_q[$];
  logic   m_iv;
  message m_im;
  logic   m_err;
  logic   pv [LAT];
  message pm [LAT];

  // Stimulus knobs
  int   p_new, p_rdy;
  logic k_start, k_flush, k_rst;
  int   n_admit, n_retire;

  function automatic message rand_msg();
    message m;
    m.ray_id    = 8'($urandom);
    m.x         = number'($urandom);
    m.y         = number'($urandom);
    m.z         = number'($urandom);
    m.threshold = number'($urandom_range(1000, 20000));
    m.r         = m.threshold - number'($urandom_range(0, 500));
    m.mb_iter   = iter_t'($urandom);
    return m;
  endfunction

  task automatic cycle();
    message rm;
    logic   rv, retire, stray, exp_ready, admit, pop;
    // the loop hands back its oldest ray with a freshly computed radius
    rv = pv[LAT-1];
    rm = pm[LAT-1];
    if (rv) begin
      if ($urandom_range(0, 4) == 0) rm.r = rm.threshold + number'($urandom_range(1, 50));
      else                           rm.r = rm.threshold - number'($urandom_range(0, 50));
    end
    rst_n      = !k_rst;
    start      = k_start;
    flush      = k_flush;
    ret_valid  = rv;
    ret_msg    = rm;
    new_valid  = ($urandom_range(0, 99) < p_new);
    new_msg    = rand_msg();
    done_ready = ($urandom_range(0, 99) < p_rdy);
    #1;
    retire    = (rm.r > rm.threshold) || (int'(rm.mb_iter) >= MAX_ITER - 1);
    stray     = rv && (m_inflight == 0);
    exp_ready = (m_st == 1) && !(rv && !retire) && (m_inflight + m_q.size() < DEPTH);
    if (!k_rst) check("new_ready", new_ready, exp_ready);
    check("busy", busy, m_st != 0);
    check("issue_valid", issue_valid, m_iv);
    if (m_iv) check("issue_msg", issue_msg, m_im);
    check("done_valid", done_valid, m_q.size() != 0);
    if (m_q.size() != 0) check("done_msg", done_msg, m_q[0]);
    check("err_sticky", err_sticky, m_err);
    @(posedge clk);
    for (int i = LAT - 1; i > 0; i--) begin
      pv[i] = pv[i-1];
      pm[i] = pm[i-1];
    end
    if (k_rst) begin
      m_st = 0; m_inflight = 0; m_q.delete(); m_iv = 1'b0; m_im = '0; m_err = 1'b0;
      pv[0] = 1'b0;
    end else begin
      admit = new_valid && exp_ready;
      pop   = (m_q.size() != 0) && done_ready;
      case (m_st)
        0: if (k_start) m_st = 1;
        1: if (k_flush) m_st = 2;
        2: if (m_inflight == 0 && m_q.size() == 0) m_st = 0;
        default: m_st = 0;
      endcase
      if (pop) void'(m_q.pop_front());
      if (rv && !stray && retire) begin
        m_q.push_back(rm);
        m_inflight--;
        n_retire++;
      end
      if (admit) begin
        m_inflight++;
        n_admit++;
      end
      if (stray) m_err = 1'b1;
      if (rv && !stray && !retire) begin
        m_iv = 1'b1;
        m_im = rm;
        m_im.mb_iter = rm.mb_iter + 1'b1;
      end else if (admit) begin
        m_iv = 1'b1;
        m_im = new_msg;
        m_im.mb_iter = '0;
      end else begin
        m_iv = 1'b0;
      end
      pv[0] = m_iv;
      pm[0] = m_im;
    end
    @(negedge clk);
  endtask

  initial begin
    logic had_rays;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; new_valid = 1'b0; new_msg = '0;
    ret_valid = 1'b0; ret_msg = '0; done_ready = 1'b0;
    m_st = 0; m_inflight = 0; m_iv = 1'b0; m_im = '0; m_err = 1'b0;
    for (int i = 0; i < LAT; i++) begin pv[i] = 1'b0; pm[i] = '0; end
    p_new = 0; p_rdy = 0; k_start = 1'b0; k_flush = 1'b0; k_rst = 1'b1;
    n_admit = 0; n_retire = 0;
    @(negedge clk);

    // reset
    cycle(); cycle();
    k_rst = 1'b0;
    cycle();
    check("rst_issue_msg", issue_msg, '0);
    check("rst_done_msg", done_msg, '0);
    $display("phase reset: checks=%0d", checks);

    // run with random traffic and back-pressure
    k_start = 1'b1; cycle(); k_start = 1'b0;
    p_new = 70; p_rdy = 50;
    for (int i = 0; i < 400; i++) cycle();
    // starve the FIFO to hit the credit limit, then release
    p_rdy = 0;
    for (int i = 0; i < 80; i++) cycle();
    p_rdy = 15;
    for (int i = 0; i < 80; i++) cycle();
    $display("phase run: admitted=%0d retired=%0d checks=%0d", n_admit, n_retire, checks);

    // flush and drain; admissions must stop, busy must fall
    k_flush = 1'b1; cycle(); k_flush = 1'b0;
    p_rdy = 60;
    for (int i = 0; i < 600 && m_st != 0; i++) cycle();
    #1 check("drain_busy", busy, 1'b0);
    $display("phase drain: retired=%0d checks=%0d", n_retire, checks);

    // restart, then reset with rays inside the loop
    k_start = 1'b1; cycle(); k_start = 1'b0;
    p_new = 100; p_rdy = 100;
    for (int i = 0; i < 12; i++) cycle();
    had_rays = 1'b0;
    for (int i = 0; i < LAT; i++) had_rays = had_rays | pv[i];
    had_rays = had_rays | m_iv;
    k_rst = 1'b1; p_new = 0; cycle(); k_rst = 1'b0;
    for (int i = 0; i < LAT + 4; i++) cycle();
    if (had_rays) check("stray_err", err_sticky, 1'b1);
    check("stray_done_valid", done_valid, 1'b0);
    $display("phase reset-in-flight: had_rays=%0b checks=%0d", had_rays, checks);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
